// File: rtl/decode_stage.sv
// decode_stage: registered RV32/RV64 decode stage, valid/ready with 2-entry skid buffer.
// Optional perf counters enabled by defining DECODE_STAGE_PERF_EN.
module decode_stage #(
    parameter int XLEN = 64,
    parameter int PC_W = XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
`ifdef DECODE_STAGE_PERF_EN
    ,
    output logic [31:0]     perf_decoded,
    output logic [31:0]     perf_illegal
`endif
);

    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_NONE = 3'd7;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    function automatic entry_t decode(
        input logic [31:0]     ins,
        input logic [PC_W-1:0] pc
    );
        entry_t      e;
        logic [31:0] imm32;
        logic [XLEN-1:0] imm;
        imm32     = '0;
        e.pc      = pc;
        e.instr   = ins;
        e.fmt     = FMT_NONE;
        e.illegal = 1'b0;
        case (ins[6:0])
            7'b0110011, 7'b0111011: e.fmt = FMT_R;
            7'b0010011, 7'b0011011, 7'b0000011,
            7'b1100111, 7'b1110011, 7'b0001111: begin
                e.fmt = FMT_I;
                imm32 = {{20{ins[31]}}, ins[31:20]};
            end
            7'b0100011: begin
                e.fmt = FMT_S;
                imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            7'b1100011: begin
                e.fmt = FMT_B;
                imm32 = {{19{ins[31]}}, ins[31], ins[7],
                         ins[30:25], ins[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                e.fmt = FMT_U;
                imm32 = {ins[31:12], 12'b0};
            end
            7'b1101111: begin
                e.fmt = FMT_J;
                imm32 = {{11{ins[31]}}, ins[31], ins[19:12],
                         ins[20], ins[30:21], 1'b0};
            end
            default: e.illegal = 1'b1;
        endcase
        if (ins[1:0] != 2'b11)
            e.illegal = 1'b1;
        // word ops and 6-bit shamts only exist on RV64
        if (XLEN == 32) begin
            if (ins[6:0] == 7'b0011011 || ins[6:0] == 7'b0111011)
                e.illegal = 1'b1;
            if (ins[6:0] == 7'b0010011 && ins[13:12] == 2'b01 && ins[25])
                e.illegal = 1'b1;
        end
        imm       = {XLEN{imm32[31]}};
        imm[31:0] = imm32;
        e.imm     = imm;
        return e;
    endfunction

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   accept;
    logic   drain;
    entry_t in_dec;

    assign in_ready  = !skid_valid_q && !flush;
    assign accept    = in_valid && in_ready;
    assign out_valid = main_valid_q;
    assign drain     = !main_valid_q || out_ready;
    assign in_dec    = decode(in_instr, in_pc);

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = in_dec;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = in_dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_pc      = main_q.pc;
    assign out_opcode  = main_q.instr[6:0];
    assign out_rd      = main_q.instr[11:7];
    assign out_funct3  = main_q.instr[14:12];
    assign out_rs1     = main_q.instr[19:15];
    assign out_rs2     = main_q.instr[24:20];
    assign out_funct7  = main_q.instr[31:25];
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;

`ifdef DECODE_STAGE_PERF_EN
    logic [31:0] perf_decoded_q;
    logic [31:0] perf_illegal_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_decoded_q <= '0;
            perf_illegal_q <= '0;
        end else if (main_valid_q && out_ready) begin
            perf_decoded_q <= perf_decoded_q + 32'd1;
            if (main_q.illegal)
                perf_illegal_q <= perf_illegal_q + 32'd1;
        end
    end

    assign perf_decoded = perf_decoded_q;
    assign perf_illegal = perf_illegal_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors for decode_stage at XLEN=64 and XLEN=32.
// Table-driven decode checks plus handshake, flush and async-reset sequences.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic        out_ready;

    logic        in_ready64, out_valid64, ill64;
    logic [63:0] pc64, imm64;
    logic [6:0]  opc64, f7_64;
    logic [4:0]  rd64, rs1_64, rs2_64;
    logic [2:0]  f3_64, fmt64;

    logic        in_ready32, out_valid32, ill32;
    logic [31:0] pc32, imm32;
    logic [6:0]  opc32, f7_32;
    logic [4:0]  rd32, rs1_32, rs2_32;
    logic [2:0]  f3_32, fmt32;

`ifdef DECODE_STAGE_PERF_EN
    logic [31:0] pd64, pi64, pd32, pi32;
`endif

    int tests;
    int fails;

    decode_stage #(.XLEN(64)) u64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_pc(pc64), .out_opcode(opc64), .out_rd(rd64),
        .out_funct3(f3_64), .out_rs1(rs1_64), .out_rs2(rs2_64),
        .out_funct7(f7_64), .out_imm(imm64), .out_fmt(fmt64),
        .out_illegal(ill64)
`ifdef DECODE_STAGE_PERF_EN
        , .perf_decoded(pd64), .perf_illegal(pi64)
`endif
    );

    decode_stage #(.XLEN(32)) u32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_pc(in_pc[31:0]),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_pc(pc32), .out_opcode(opc32), .out_rd(rd32),
        .out_funct3(f3_32), .out_rs1(rs1_32), .out_rs2(rs2_32),
        .out_funct7(f7_32), .out_imm(imm32), .out_fmt(fmt32),
        .out_illegal(ill32)
`ifdef DECODE_STAGE_PERF_EN
        , .perf_decoded(pd32), .perf_illegal(pi32)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] ins, input logic [63:0] pc);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        step();
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic [63:0] imm64;
        logic        ill64;
        logic [31:0] imm32;
        logic        ill32;
    } vec_t;

    vec_t v[13];

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b1;

        v[0]  = '{32'h00500093, 3'd1, 64'h5, 1'b0, 32'h5, 1'b0};
        v[1]  = '{32'hFE000EE3, 3'd3, 64'hFFFFFFFFFFFFFFFC, 1'b0, 32'hFFFFFFFC, 1'b0};
        v[2]  = '{32'h0010009B, 3'd1, 64'h1, 1'b0, 32'h1, 1'b1};
        v[3]  = '{32'h02009093, 3'd1, 64'h20, 1'b0, 32'h20, 1'b1};
        v[4]  = '{32'h00000000, 3'd7, 64'h0, 1'b1, 32'h0, 1'b1};
        v[5]  = '{32'h003100B3, 3'd0, 64'h0, 1'b0, 32'h0, 1'b0};
        v[6]  = '{32'h0020A223, 3'd2, 64'h4, 1'b0, 32'h4, 1'b0};
        v[7]  = '{32'h800002B7, 3'd4, 64'hFFFFFFFF80000000, 1'b0, 32'h80000000, 1'b0};
        v[8]  = '{32'hFFDFF0EF, 3'd5, 64'hFFFFFFFFFFFFFFFC, 1'b0, 32'hFFFFFFFC, 1'b0};
        v[9]  = '{32'h00000001, 3'd7, 64'h0, 1'b1, 32'h0, 1'b1};
        v[10] = '{32'h00000073, 3'd1, 64'h0, 1'b0, 32'h0, 1'b0};
        v[11] = '{32'h4010D093, 3'd1, 64'h401, 1'b0, 32'h401, 1'b0};
        v[12] = '{32'h003100BB, 3'd0, 64'h0, 1'b0, 32'h0, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid64", {63'd0, out_valid64}, 64'd0);
        chk("rst out_valid32", {63'd0, out_valid32}, 64'd0);
        chk("rst out_fmt", {61'd0, fmt64}, 64'd0);
        chk("rst out_imm", imm64, 64'd0);
        chk("rst out_pc", pc64, 64'd0);
        rst = 1'b0;
        #1;
        chk("rst in_ready", {63'd0, in_ready64}, 64'd1);

        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1;
            in_instr = v[i].instr;
            in_pc    = 64'h8000_0000_0000_0000 + 64'(i * 4);
            step();
            chk($sformatf("v%0d valid", i), {63'd0, out_valid64}, 64'd1);
            chk($sformatf("v%0d pc", i), pc64, in_pc);
            chk($sformatf("v%0d rd", i), {59'd0, rd64}, {59'd0, v[i].instr[11:7]});
            chk($sformatf("v%0d rs1", i), {59'd0, rs1_64}, {59'd0, v[i].instr[19:15]});
            chk($sformatf("v%0d rs2", i), {59'd0, rs2_32}, {59'd0, v[i].instr[24:20]});
            chk($sformatf("v%0d opf", i), {50'd0, f7_64, f3_64, opc64},
                {50'd0, v[i].instr[31:25], v[i].instr[14:12], v[i].instr[6:0]});
            chk($sformatf("v%0d fmt64", i), {61'd0, fmt64}, {61'd0, v[i].fmt});
            chk($sformatf("v%0d fmt32", i), {61'd0, fmt32}, {61'd0, v[i].fmt});
            chk($sformatf("v%0d imm64", i), imm64, v[i].imm64);
            chk($sformatf("v%0d imm32", i), {32'd0, imm32}, {32'd0, v[i].imm32});
            chk($sformatf("v%0d ill64", i), {63'd0, ill64}, {63'd0, v[i].ill64});
            chk($sformatf("v%0d ill32", i), {63'd0, ill32}, {63'd0, v[i].ill32});
        end
        in_valid = 1'b0;
        step();
        chk("drain idle", {63'd0, out_valid64}, 64'd0);

        // backpressure: A to main, B to skid, C refused
        out_ready = 1'b0;
        push(32'h00100093, 64'h100);
        push(32'h00200113, 64'h104);
        chk("bp in_ready full", {63'd0, in_ready64}, 64'd0);
        in_valid = 1'b1;
        in_instr = 32'h00300193;
        in_pc    = 64'h108;
        step();
        chk("bp frozen pc", pc64, 64'h100);
        chk("bp frozen imm", imm64, 64'h1);
        chk("bp still refusing", {63'd0, in_ready64}, 64'd0);
        out_ready = 1'b1;
        step();
        chk("bp order B", pc64, 64'h104);
        chk("bp B rd", {59'd0, rd64}, 64'd2);
        chk("bp ready again", {63'd0, in_ready64}, 64'd1);
        step();
        chk("bp order C", pc64, 64'h108);
        chk("bp C valid", {63'd0, out_valid64}, 64'd1);
        in_valid = 1'b0;
        step();
        chk("bp empty", {63'd0, out_valid64}, 64'd0);

        // flush with both entries full
        out_ready = 1'b0;
        push(32'h00100093, 64'h200);
        push(32'h00200113, 64'h204);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h00400213;
        in_pc    = 64'h208;
        #1;
        chk("flush in_ready", {63'd0, in_ready64}, 64'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush out_valid", {63'd0, out_valid64}, 64'd0);
        chk("flush in_ready after", {63'd0, in_ready64}, 64'd1);
        out_ready = 1'b1;
        step();
        chk("flush no ghost", {63'd0, out_valid64}, 64'd0);
        push(32'h00500293, 64'h300);
        chk("post flush pc", pc64, 64'h300);

        // async reset mid-stream with skid full
        out_ready = 1'b0;
        push(32'h00100093, 64'h400);
        push(32'h00200113, 64'h404);
        chk("pre-rst valid", {63'd0, out_valid64}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst valid64", {63'd0, out_valid64}, 64'd0);
        chk("async rst valid32", {63'd0, out_valid32}, 64'd0);
        chk("async rst in_ready", {63'd0, in_ready64}, 64'd1);
`ifdef DECODE_STAGE_PERF_EN
        chk("perf decoded 0", {32'd0, pd64}, 64'd0);
        chk("perf illegal 0", {32'd0, pi32}, 64'd0);
`endif
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        chk("after rst empty", {63'd0, out_valid64}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
